// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - state encoding, error codes and defaults shared by the UART packet controller
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Running checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload register file, one synchronous write port and one combinational read port
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    // Storage is deliberately left without reset; contents are only read after being written.
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - frames UART bytes (SYNC, LEN, payload, CSUM) into checked packets; PKT_STATS_EN adds good/bad counters
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 208_333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        overrun,
    output logic        busy
`ifdef PKT_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int             PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_len;
    logic [7:0]    r_sum;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [TW-1:0] r_timer;
    logic          r_pkt_err;
    logic          r_overrun;
    logic [1:0]    r_err_code;

    logic          w_timed;
    logic          w_tmo;
    logic          w_len_ok;
    logic          w_wr_last;
    logic          w_rd_last;
    logic          w_drain;
    logic          w_xfer;
    logic          w_err;
    logic [1:0]    w_err_code;
    logic          w_buf_we;
    logic          w_csum_ok;
    logic [7:0]    w_buf_rd;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (PW)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_buf_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (rx_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_buf_rd)
    );

    assign w_timed   = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CSUM);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_tmo     = w_timed && !rx_done && (r_timer == TMO_LAST);
    assign w_len_ok  = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign w_wr_last = (8'(r_wr_ptr) == (r_len - 8'd1));
    assign w_rd_last = (8'(r_rd_ptr) == (r_len - 8'd1));
    assign w_drain   = (r_state == DRAIN);
    assign w_xfer    = w_drain && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_code  = ERR_NONE;
        w_buf_we    = 1'b0;
        w_csum_ok   = 1'b0;
        case (r_state)
            HUNT: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = LEN;
                end
            end
            LEN: begin
                if (rx_done) begin
                    if (w_len_ok) begin
                        w_state_nxt = PAYLOAD;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_LEN;
                        w_state_nxt = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_done) begin
                    w_buf_we = 1'b1;
                    if (w_wr_last) begin
                        w_state_nxt = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_done) begin
                    if (rx_data == r_sum) begin
                        w_csum_ok   = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_CSUM;
                        w_state_nxt = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (w_xfer && w_rd_last) begin
                    w_state_nxt = HUNT;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
        if (w_tmo) begin
            w_err       = 1'b1;
            w_err_code  = ERR_TMO;
            w_state_nxt = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= 8'd0;
            r_sum      <= 8'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_timer    <= '0;
            r_pkt_err  <= 1'b0;
            r_overrun  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_pkt_err <= w_err;
            // Bytes arriving while draining are dropped, not scanned for SYNC.
            r_overrun <= w_drain && rx_done;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
            if ((r_state == LEN) && rx_done && w_len_ok) begin
                r_len    <= rx_data;
                r_sum    <= rx_data;
                r_wr_ptr <= '0;
            end
            if (w_buf_we) begin
                r_sum    <= csum_add(r_sum, rx_data);
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_csum_ok) begin
                r_rd_ptr <= '0;
            end else if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (!w_timed || rx_done || w_tmo) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    assign out_valid = w_drain;
    assign out_data  = w_drain ? w_buf_rd : 8'd0;
    assign out_last  = w_drain && w_rd_last;
    assign pkt_err   = r_pkt_err;
    assign err_code  = r_err_code;
    assign overrun   = r_overrun;
    assign busy      = (r_state != HUNT);

`ifdef PKT_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else begin
            if (w_csum_ok && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_err && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule
